// File: rtl/ex_multicycle_sequencer_pkg.sv
// Shared encodings for the EX multi-cycle sequencer: unit ids, FSM states
// and the fixed-priority unit selector (atomic > mul/div > fpu).
package ex_multicycle_sequencer_pkg;

    localparam logic [1:0] UNIT_NONE   = 2'd0;
    localparam logic [1:0] UNIT_MULDIV = 2'd1;
    localparam logic [1:0] UNIT_ATOMIC = 2'd2;
    localparam logic [1:0] UNIT_FPU    = 2'd3;

    localparam logic [1:0] SEQ_IDLE = 2'd0;
    localparam logic [1:0] SEQ_WAIT = 2'd1;
    localparam logic [1:0] SEQ_POST = 2'd2;

    // Later assignments win, giving atomic the highest priority.
    function automatic logic [1:0] pick_unit(
        input logic atomic,
        input logic mul_div,
        input logic fp
    );
        logic [1:0] u;
        u = UNIT_NONE;
        if (fp) u = UNIT_FPU;
        if (mul_div) u = UNIT_MULDIV;
        if (atomic) u = UNIT_ATOMIC;
        return u;
    endfunction

endpackage

// File: rtl/ex_multicycle_sequencer_if.sv
// Bundle between the core pipeline/units and the EX multi-cycle sequencer.
// master: pipeline side (drives EX/ID info, done pulses, mmu/flush);
// slave: sequencer (drives starts, kill, holds, stalls, active unit, error).
interface ex_multicycle_sequencer_if #(
    parameter int RD_W = 5
);

    logic            idex_valid;
    logic            idex_is_mul_div;
    logic            idex_is_atomic;
    logic            idex_fp_multi;
    logic [RD_W-1:0] idex_rd;
    logic [RD_W-1:0] ifid_rs1;
    logic [RD_W-1:0] ifid_rs2;
    logic            mul_div_done;
    logic            atomic_done;
    logic            fpu_done;
    logic            mmu_busy;
    logic            flush_ex;

    logic            mul_div_start;
    logic            atomic_start;
    logic            fpu_start;
    logic            unit_kill;
    logic            hold_idex;
    logic            hold_exmem;
    logic            seq_stall_front;
    logic            seq_bubble_idex;
    logic [1:0]      active_unit;
    logic            timeout_err;

    modport master (
        output idex_valid, idex_is_mul_div, idex_is_atomic, idex_fp_multi,
        output idex_rd, ifid_rs1, ifid_rs2,
        output mul_div_done, atomic_done, fpu_done, mmu_busy, flush_ex,
        input  mul_div_start, atomic_start, fpu_start, unit_kill,
        input  hold_idex, hold_exmem, seq_stall_front, seq_bubble_idex,
        input  active_unit, timeout_err
    );

    modport slave (
        input  idex_valid, idex_is_mul_div, idex_is_atomic, idex_fp_multi,
        input  idex_rd, ifid_rs1, ifid_rs2,
        input  mul_div_done, atomic_done, fpu_done, mmu_busy, flush_ex,
        output mul_div_start, atomic_start, fpu_start, unit_kill,
        output hold_idex, hold_exmem, seq_stall_front, seq_bubble_idex,
        output active_unit, timeout_err
    );

endinterface

// File: rtl/ex_multicycle_sequencer_dep_compare.sv
// Integer RAW check of one destination against the two ID sources.
// Ports: rd_i, rs1_i, rs2_i (register indices) -> dep_o (x0 never matches).
module ex_dep_compare #(
    parameter int RD_W = 5
) (
    input  logic [RD_W-1:0] rd_i,
    input  logic [RD_W-1:0] rs1_i,
    input  logic [RD_W-1:0] rs2_i,
    output logic            dep_o
);

    assign dep_o = (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/ex_multicycle_sequencer.sv
// Sequences the shared EX multi-cycle units: one start per op, holds
// IDEX/EXMEM until done, one-cycle post-completion dependency stall,
// flush/watchdog kill. Ports: clk, reset_n (sync, active low), seq (slave).
module ex_multicycle_sequencer
    import ex_multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int XLEN_RD_W      = 5
) (
    input logic                      clk,
    input logic                      reset_n,
    ex_multicycle_sequencer_if.slave seq
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           unit_q, unit_d;
    logic [XLEN_RD_W-1:0] rd_q, rd_d;
    logic                 timeout_q, timeout_d;

    logic       req;
    logic [1:0] sel;
    logic       sel_done;
    logic       dep_live;
    logic       dep_post;

    logic       md_start;
    logic       at_start;
    logic       fp_start;
    logic       kill;
    logic       hold;
    logic       stall;
    logic       bubble;
    logic [1:0] act;

    // Done-cycle check uses the op still sitting in EX; POST uses the
    // captured rd because IDEX has moved on by then.
    ex_dep_compare #(.RD_W(XLEN_RD_W)) u_dep_live (
        .rd_i  (seq.idex_rd),
        .rs1_i (seq.ifid_rs1),
        .rs2_i (seq.ifid_rs2),
        .dep_o (dep_live)
    );

    ex_dep_compare #(.RD_W(XLEN_RD_W)) u_dep_post (
        .rd_i  (rd_q),
        .rs1_i (seq.ifid_rs1),
        .rs2_i (seq.ifid_rs2),
        .dep_o (dep_post)
    );

    assign req = seq.idex_valid
               & (seq.idex_is_atomic | seq.idex_is_mul_div | seq.idex_fp_multi);
    assign sel = pick_unit(seq.idex_is_atomic, seq.idex_is_mul_div,
                           seq.idex_fp_multi);

    always_comb begin
        sel_done = 1'b0;
        case (unit_q)
            UNIT_MULDIV: sel_done = seq.mul_div_done;
            UNIT_ATOMIC: sel_done = seq.atomic_done;
            UNIT_FPU:    sel_done = seq.fpu_done;
            default:     sel_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        unit_d    = unit_q;
        rd_d      = rd_q;
        timeout_d = timeout_q;
        md_start  = 1'b0;
        at_start  = 1'b0;
        fp_start  = 1'b0;
        kill      = 1'b0;
        hold      = 1'b0;
        stall     = 1'b0;
        bubble    = 1'b0;
        act       = UNIT_NONE;

        if (seq.mmu_busy) begin
            // Page walk freezes everything and keeps the pipe parked.
            hold  = 1'b1;
            stall = 1'b1;
            if (state_q == SEQ_WAIT) act = unit_q;
        end else begin
            unique case (state_q)
                SEQ_WAIT: begin
                    act = unit_q;
                    if (seq.flush_ex) begin
                        kill    = 1'b1;
                        act     = UNIT_NONE;
                        unit_d  = UNIT_NONE;
                        state_d = SEQ_IDLE;
                    end else if (sel_done) begin
                        unit_d = UNIT_NONE;
                        if (unit_q == UNIT_FPU) begin
                            state_d = SEQ_IDLE;
                        end else begin
                            stall   = dep_live;
                            bubble  = dep_live;
                            state_d = SEQ_POST;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        kill      = 1'b1;
                        act       = UNIT_NONE;
                        timeout_d = 1'b1;
                        unit_d    = UNIT_NONE;
                        state_d   = SEQ_IDLE;
                    end else begin
                        hold  = 1'b1;
                        stall = 1'b1;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    if (state_q == SEQ_POST) begin
                        stall  = dep_post;
                        bubble = dep_post;
                    end
                    state_d = SEQ_IDLE;
                    if (req && !seq.flush_ex) begin
                        md_start = (sel == UNIT_MULDIV);
                        at_start = (sel == UNIT_ATOMIC);
                        fp_start = (sel == UNIT_FPU);
                        hold     = 1'b1;
                        stall    = 1'b1;
                        bubble   = 1'b0;
                        act      = sel;
                        unit_d   = sel;
                        rd_d     = seq.idex_rd;
                        cnt_d    = '0;
                        state_d  = SEQ_WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= SEQ_IDLE;
            cnt_q     <= '0;
            unit_q    <= UNIT_NONE;
            rd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            unit_q    <= unit_d;
            rd_q      <= rd_d;
            timeout_q <= timeout_d;
        end
    end

    // Mealy outputs are quiet while reset is asserted.
    assign seq.mul_div_start   = reset_n & md_start;
    assign seq.atomic_start    = reset_n & at_start;
    assign seq.fpu_start       = reset_n & fp_start;
    assign seq.unit_kill       = reset_n & kill;
    assign seq.hold_idex       = reset_n & hold;
    assign seq.hold_exmem      = reset_n & hold;
    assign seq.seq_stall_front = reset_n & stall;
    assign seq.seq_bubble_idex = reset_n & bubble;
    assign seq.active_unit     = reset_n ? act : UNIT_NONE;
    assign seq.timeout_err     = timeout_q;

endmodule

// File: tb/tb_ex_multicycle_sequencer.sv
// Scenario bench for ex_multicycle_sequencer (TIMEOUT_CYCLES=8).
// Output vector: {mstart,astart,fstart,kill,hidex,hexmem,stall,bubble,unit[1:0],terr}
module tb_ex_multicycle_sequencer;
    import ex_multicycle_sequencer_pkg::*;

    typedef struct packed {
        logic       rn;
        logic       v;
        logic       a;
        logic       m;
        logic       f;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       md;
        logic       ad;
        logic       fd;
        logic       mmu;
        logic       fl;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] sb[$];

    ex_multicycle_sequencer_if #(.RD_W(5)) bus ();

    ex_multicycle_sequencer #(
        .TIMEOUT_CYCLES (8),
        .XLEN_RD_W      (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .seq     (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(
        input logic v, input logic a, input logic m, input logic f,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic md, input logic ad, input logic fd,
        input logic mmu, input logic fl
    );
        stim_t s;
        s.rn = 1'b1;
        s.v = v; s.a = a; s.m = m; s.f = f;
        s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.md = md; s.ad = ad; s.fd = fd;
        s.mmu = mmu; s.fl = fl;
        return s;
    endfunction

    function automatic logic [10:0] E(
        input logic ms, input logic as_, input logic fs, input logic kl,
        input logic hd, input logic st, input logic bb,
        input logic [1:0] au, input logic te
    );
        return {ms, as_, fs, kl, hd, hd, st, bb, au, te};
    endfunction

    function automatic logic [10:0] outs();
        return {bus.mul_div_start, bus.atomic_start, bus.fpu_start,
                bus.unit_kill, bus.hold_idex, bus.hold_exmem,
                bus.seq_stall_front, bus.seq_bubble_idex,
                bus.active_unit, bus.timeout_err};
    endfunction

    task automatic apply(input stim_t s, input logic [10:0] x);
        @(negedge clk);
        reset_n             = s.rn;
        bus.idex_valid      = s.v;
        bus.idex_is_atomic  = s.a;
        bus.idex_is_mul_div = s.m;
        bus.idex_fp_multi   = s.f;
        bus.idex_rd         = s.rd;
        bus.ifid_rs1        = s.rs1;
        bus.ifid_rs2        = s.rs2;
        bus.mul_div_done    = s.md;
        bus.atomic_done     = s.ad;
        bus.fpu_done        = s.fd;
        bus.mmu_busy        = s.mmu;
        bus.flush_ex        = s.fl;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        stim_t sq[$];
        logic [10:0] eq[$];
        stim_t t;
        logic [10:0] got, want;
        t = S(1,0,1,0,5,5,0,0,0,0,0,0); t.rn = 1'b0;
        sq.push_back(t);                          eq.push_back(11'd0);
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        sq.push_back(S(1,0,1,0,5,5,0,0,0,0,0,0)); eq.push_back(E(1,0,0,0,1,1,0,1,0));
        sq.push_back(t);                          eq.push_back(11'd0);
        sq.push_back(S(0,0,0,0,0,0,0,1,0,0,0,0)); eq.push_back(11'd0);
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_mul_dep();
        stim_t sq[$];
        logic [10:0] eq[$];
        logic [10:0] got, want;
        sq.push_back(S(1,0,1,0,5,5,0,0,0,0,0,0)); eq.push_back(E(1,0,0,0,1,1,0,1,0));
        for (int k = 0; k < 3; k++) begin
            sq.push_back(S(1,0,1,0,5,5,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,1,1,0,1,0));
        end
        sq.push_back(S(1,0,1,0,5,5,0,1,0,0,0,0)); eq.push_back(E(0,0,0,0,0,1,1,1,0));
        sq.push_back(S(0,0,0,0,0,5,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,0,1,1,0,0));
        sq.push_back(S(0,0,0,0,0,5,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mul_dep[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_amo_x0();
        stim_t sq[$];
        logic [10:0] eq[$];
        logic [10:0] got, want;
        sq.push_back(S(1,1,0,0,0,0,0,0,0,0,0,0)); eq.push_back(E(0,1,0,0,1,1,0,2,0));
        sq.push_back(S(1,1,0,0,0,0,0,0,0,1,0,0)); eq.push_back(E(0,0,0,0,1,1,0,2,0));
        sq.push_back(S(1,1,0,0,0,0,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,1,1,0,2,0));
        sq.push_back(S(1,1,0,0,0,0,0,0,1,0,0,0)); eq.push_back(E(0,0,0,0,0,0,0,2,0));
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL amo_x0[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_priority();
        stim_t sq[$];
        logic [10:0] eq[$];
        logic [10:0] got, want;
        sq.push_back(S(1,1,1,0,7,1,2,0,0,0,0,0)); eq.push_back(E(0,1,0,0,1,1,0,2,0));
        sq.push_back(S(1,1,1,0,7,1,2,1,0,0,0,0)); eq.push_back(E(0,0,0,0,1,1,0,2,0));
        sq.push_back(S(1,1,1,0,7,1,2,0,1,0,0,0)); eq.push_back(E(0,0,0,0,0,0,0,2,0));
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL priority[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_flush();
        stim_t sq[$];
        logic [10:0] eq[$];
        logic [10:0] got, want;
        sq.push_back(S(1,0,1,0,3,3,0,0,0,0,0,0)); eq.push_back(E(1,0,0,0,1,1,0,1,0));
        sq.push_back(S(1,0,1,0,3,3,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,1,1,0,1,0));
        sq.push_back(S(1,0,1,0,3,3,0,1,0,0,0,1)); eq.push_back(E(0,0,0,1,0,0,0,0,0));
        sq.push_back(S(0,0,0,0,0,3,0,0,0,0,0,0)); eq.push_back(11'd0);
        sq.push_back(S(1,0,1,0,3,3,0,0,0,0,0,1)); eq.push_back(11'd0);
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL flush[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_mmu();
        stim_t sq[$];
        logic [10:0] eq[$];
        logic [10:0] got, want;
        for (int k = 0; k < 3; k++) begin
            sq.push_back(S(1,0,0,1,4,0,0,0,0,0,1,0)); eq.push_back(E(0,0,0,0,1,1,0,0,0));
        end
        sq.push_back(S(1,0,0,1,4,0,0,0,0,0,0,0)); eq.push_back(E(0,0,1,0,1,1,0,3,0));
        sq.push_back(S(1,0,0,1,4,0,0,0,0,0,1,0)); eq.push_back(E(0,0,0,0,1,1,0,3,0));
        sq.push_back(S(1,0,0,1,4,4,0,0,0,1,0,0)); eq.push_back(E(0,0,0,0,0,0,0,3,0));
        sq.push_back(S(0,0,0,0,0,4,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mmu[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t sq[$];
        logic [10:0] eq[$];
        logic [10:0] got, want;
        sq.push_back(S(1,0,1,0,6,1,0,0,0,0,0,0)); eq.push_back(E(1,0,0,0,1,1,0,1,0));
        sq.push_back(S(1,0,1,0,6,1,0,1,0,0,0,0)); eq.push_back(E(0,0,0,0,0,0,0,1,0));
        sq.push_back(S(1,0,1,0,7,7,0,0,0,0,0,0)); eq.push_back(E(1,0,0,0,1,1,0,1,0));
        sq.push_back(S(1,0,1,0,7,7,0,1,0,0,0,0)); eq.push_back(E(0,0,0,0,0,1,1,1,0));
        sq.push_back(S(0,0,0,0,0,7,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,0,1,1,0,0));
        sq.push_back(S(0,0,0,0,0,7,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL b2b[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t sq[$];
        logic [10:0] eq[$];
        stim_t t;
        logic [10:0] got, want;
        sq.push_back(S(1,0,0,1,9,0,0,0,0,0,0,0)); eq.push_back(E(0,0,1,0,1,1,0,3,0));
        for (int k = 0; k < 8; k++) begin
            sq.push_back(S(1,0,0,1,9,0,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,1,1,0,3,0));
        end
        sq.push_back(S(1,0,0,1,9,0,0,0,0,0,0,0)); eq.push_back(E(0,0,0,1,0,0,0,0,0));
        for (int k = 0; k < 2; k++) begin
            sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(E(0,0,0,0,0,0,0,0,1));
        end
        t = S(0,0,0,0,0,0,0,0,0,0,0,0); t.rn = 1'b0;
        sq.push_back(t);                          eq.push_back(E(0,0,0,0,0,0,0,0,1));
        sq.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0)); eq.push_back(11'd0);
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            #2;
            want = sb.pop_front();
            got = outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL timeout[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    initial begin
        bus.idex_valid      = 1'b0;
        bus.idex_is_atomic  = 1'b0;
        bus.idex_is_mul_div = 1'b0;
        bus.idex_fp_multi   = 1'b0;
        bus.idex_rd         = 5'd0;
        bus.ifid_rs1        = 5'd0;
        bus.ifid_rs2        = 5'd0;
        bus.mul_div_done    = 1'b0;
        bus.atomic_done     = 1'b0;
        bus.fpu_done        = 1'b0;
        bus.mmu_busy        = 1'b0;
        bus.flush_ex        = 1'b0;
        test_reset();
        test_mul_dep();
        test_amo_x0();
        test_priority();
        test_flush();
        test_mmu();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
